// File: rtl/dds_multich_sweep_avalon_slave_if.sv
// Avalon-MM slave bus bundle for the multichannel DDS sweep block.
//   chipselect/write/read : bus strobes (write/read qualified by chipselect)
//   address               : [2:0] register, upper bits channel index
//   writedata/readdata    : 32-bit data; readdata is registered (latency 1)
interface dds_multich_sweep_avalon_slave_if #(
  parameter int N_CH = 2
) ();
  localparam int AW = $clog2(N_CH) + 3;

  logic          chipselect;
  logic          write;
  logic          read;
  logic [AW-1:0] address;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/dds_multich_sweep_avalon_slave.sv
// Multichannel DDS phase generator with per-channel FTW sweep engines,
// programmed over an Avalon-MM slave.
//   clock, reset   : system clock, synchronous active-high reset
//   bus            : Avalon-MM slave (see the interface file)
//   o_phase        : N_CH packed phases, OUT_WIDTH bits each, ch0 in LSBs
//   o_sweep_done   : per-channel sticky done flags
//   o_irq          : OR over channels of (done & irq_en)

// One DDS lane: register file, sweep FSM, phase accumulator.
//   we/wreg/wdata  : register write for this lane
//   rreg/rdata     : combinational register readback
//   phase/done/irq : lane outputs
module dds_sweep_ch #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 14,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [2:0]           wreg,
  input  logic [31:0]          wdata,
  input  logic [2:0]           rreg,
  output logic [31:0]          rdata,
  output logic [OUT_WIDTH-1:0] phase,
  output logic                 done,
  output logic                 irq
);
  localparam int AW = ACC_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, DONE = 2'd3} state_t;

  state_t                 state;
  logic                   enable, sweep_en, mode, irq_en;
  logic [AW-1:0]          ftw_start, ftw_stop, ftw_step, phase_off;
  logic [AW-1:0]          ftw_reg, acc;
  logic [DWELL_WIDTH-1:0] dwell, dwell_cnt;

  logic [AW-1:0] ftw_cur, phase_sum;
  logic [AW:0]   up_sum, dn_diff;
  logic          up_hit, dn_hit, ctrl_we;

  // While idle the live FTW tracks START so a static tone follows writes.
  assign ftw_cur   = (state == IDLE) ? ftw_start : ftw_reg;
  assign phase_sum = acc + phase_off;

  // One extra bit so neither direction can wrap past the limits.
  assign up_sum  = {1'b0, ftw_reg} + {1'b0, ftw_step};
  assign dn_diff = {1'b0, ftw_reg} - {1'b0, ftw_step};
  assign up_hit  = up_sum >= {1'b0, ftw_stop};
  assign dn_hit  = dn_diff[AW] | (dn_diff[AW-1:0] <= ftw_start);

  assign ctrl_we = we && (wreg == 3'd0);
  assign irq     = done & irq_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      enable    <= 1'b0;
      sweep_en  <= 1'b0;
      mode      <= 1'b0;
      irq_en    <= 1'b0;
      ftw_start <= '0;
      ftw_stop  <= '0;
      ftw_step  <= '0;
      phase_off <= '0;
      ftw_reg   <= '0;
      acc       <= '0;
      dwell     <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
      phase     <= '0;
    end else begin
      // W1C first so any set later in this block wins.
      if (we && (wreg == 3'd6) && wdata[2]) done <= 1'b0;

      unique case (state)
        UP, DOWN: begin
          if (dwell_cnt == dwell) begin
            dwell_cnt <= '0;
            if (ftw_step != '0) begin
              if (state == UP) begin
                if (up_hit) begin
                  ftw_reg <= ftw_stop;
                  if (mode) state <= DOWN;
                  else begin
                    state <= DONE;
                    done  <= 1'b1;
                  end
                end else begin
                  ftw_reg <= up_sum[AW-1:0];
                end
              end else begin
                if (dn_hit) begin
                  ftw_reg <= ftw_start;
                  state   <= UP;
                end else begin
                  ftw_reg <= dn_diff[AW-1:0];
                end
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
          end
        end
        default: ;
      endcase

      // Register writes come after the FSM so a CTRL write overrides stepping.
      if (we) begin
        unique case (wreg)
          3'd0: begin
            enable   <= wdata[0];
            sweep_en <= wdata[1];
            mode     <= wdata[2];
            irq_en   <= wdata[4];
            if (wdata[1] && !sweep_en) begin
              ftw_reg   <= ftw_start;
              dwell_cnt <= '0;
              if (ftw_start > ftw_stop) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= UP;
              end
            end else if (!wdata[1]) begin
              state <= IDLE;
            end
          end
          3'd1: ftw_start <= wdata[AW-1:0];
          3'd2: ftw_stop  <= wdata[AW-1:0];
          3'd3: ftw_step  <= wdata[AW-1:0];
          3'd4: dwell     <= wdata[DWELL_WIDTH-1:0];
          3'd5: phase_off <= wdata[AW-1:0];
          default: ;
        endcase
      end

      // phase_clr overrides accumulation for one cycle.
      if (ctrl_we && wdata[3]) acc <= '0;
      else if (enable)         acc <= acc + ftw_cur;

      phase <= phase_sum[AW-1 -: OUT_WIDTH];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (rreg)
      3'd0: rdata = {27'd0, irq_en, 1'b0, mode, sweep_en, enable};
      3'd1: rdata = 32'(ftw_start);
      3'd2: rdata = 32'(ftw_stop);
      3'd3: rdata = 32'(ftw_step);
      3'd4: rdata = 32'(dwell);
      3'd5: rdata = 32'(phase_off);
      3'd6: rdata = {29'd0, done, state};
      3'd7: rdata = 32'(ftw_cur);
    endcase
  end
endmodule

module dds_multich_sweep_avalon_slave #(
  parameter int N_CH        = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 14,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  dds_multich_sweep_avalon_slave_if.slave bus,
  output logic [N_CH*OUT_WIDTH-1:0]     o_phase,
  output logic [N_CH-1:0]               o_sweep_done,
  output logic                          o_irq
);
  localparam int AW = $clog2(N_CH) + 3;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CW-1:0]                   ch_idx;
  logic                            ch_ok, wr_any;
  logic [N_CH-1:0][31:0]           ch_rdata;
  logic [N_CH-1:0][OUT_WIDTH-1:0]  ch_phase;
  logic [N_CH-1:0]                 ch_done, ch_irq;
  logic [31:0]                     rsel;

  generate
    if (N_CH > 1) begin : g_idx
      assign ch_idx = bus.address[AW-1:3];
    end else begin : g_idx1
      assign ch_idx = '0;
    end
  endgenerate

  // Non-power-of-two N_CH leaves unused channel codes; those are dead.
  assign ch_ok  = 32'(ch_idx) < 32'(N_CH);
  assign wr_any = bus.chipselect & bus.write & ch_ok;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      dds_sweep_ch #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .DWELL_WIDTH(DWELL_WIDTH)
      ) u_ch (
        .clock (clock),
        .reset (reset),
        .we    (wr_any && (ch_idx == CW'(c))),
        .wreg  (bus.address[2:0]),
        .wdata (bus.writedata),
        .rreg  (bus.address[2:0]),
        .rdata (ch_rdata[c]),
        .phase (ch_phase[c]),
        .done  (ch_done[c]),
        .irq   (ch_irq[c])
      );
    end
  endgenerate

  assign o_phase      = ch_phase;
  assign o_sweep_done = ch_done;
  assign o_irq        = |ch_irq;

  always_comb begin
    rsel = '0;
    for (int c = 0; c < N_CH; c++)
      if (ch_idx == CW'(c)) rsel = ch_rdata[c];
  end

  // Readback samples pre-write register state, so a read of a register
  // written in the same cycle returns the old value.
  always_ff @(posedge clock) begin
    if (reset)                              bus.readdata <= '0;
    else if (bus.chipselect && bus.read)    bus.readdata <= ch_ok ? rsel : 32'd0;
  end
endmodule

// File: doc/dds_multich_sweep_avalon_slave.md
Name: dds_multich_sweep_avalon_slave

Overview:
- Avalon-MM slave driving N_CH independent DDS phase accumulators.
- Each channel has its own frequency tuning word (FTW), phase offset and hardware frequency-sweep engine (one-shot or triangle), with a sticky done flag and an interrupt.
- It feeds external sin/cos LUT/DAC paths and replaces single-channel, button-stepped tuning with register-programmed sweeps.

Parameters:
N_CH, 2, number of DDS channels (1..8)
ACC_WIDTH, 32, phase accumulator / FTW / offset width (≤32)
OUT_WIDTH, 14, phase bits presented per channel (MSBs of accumulator+offset)
DWELL_WIDTH, 16, width of per-step dwell counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe (qualified by chipselect)
read  in  1  Avalon read strobe (qualified by chipselect)
address  in  $clog2(N_CH)+3  word address; [2:0]=register, upper bits=channel
writedata  in  32  write data
readdata  out  32  read data, fixed read latency 1
o_phase  out  N_CH*OUT_WIDTH  packed channel phases, ch0 in LSBs
o_sweep_done  out  N_CH  per-channel sticky done flags
o_irq  out  1  OR over channels of (done & irq_en)

Behaviour:
- Register map, per channel:
  - 0 CTRL RW: b0 enable, b1 sweep_en, b2 mode (0 one-shot, 1 triangle), b3 phase_clr (write-only pulse, reads 0), b4 irq_en
  - 1 FTW_START RW
  - 2 FTW_STOP RW
  - 3 FTW_STEP RW
  - 4 DWELL RW, low DWELL_WIDTH bits
  - 5 PHASE_OFFSET RW
  - 6 STATUS: b1:0 state RO, b2 done W1C
  - 7 FTW_CUR RO
- Unimplemented upper bits read 0. Writes to RO fields are ignored. Channel index ≥ N_CH: writes ignored, reads 0.
- Reads: readdata registered, valid the cycle after read&chipselect. Holds last value otherwise. 0 after reset.
- Reset: all registers 0; FSM IDLE; accumulators 0; o_phase, o_sweep_done, o_irq, readdata all 0. Reset mid-sweep aborts immediately, no residual state.
- Accumulator:
  - enable=1: acc <= acc + FTW_CUR each cycle, wrapping modulo 2^ACC_WIDTH.
  - enable=0: acc holds.
  - phase_clr write: acc <= 0 that cycle, overriding accumulate; accumulation resumes next cycle if enabled.
- o_phase: registered (acc + PHASE_OFFSET) mod 2^ACC_WIDTH, top OUT_WIDTH bits. 1 cycle latency from acc.
- Sweep FSM per channel; STATUS state encoding IDLE=0, UP=1, DOWN=2, DONE=3.
  - IDLE: FTW_CUR = FTW_START, tracking live writes.
  - Start: a CTRL write with sweep_en 0→1 moves to UP, loads FTW_CUR=FTW_START, clears dwell counter. Does not clear done.
  - Start with FTW_START > FTW_STOP: go straight to DONE, FTW_CUR=FTW_START, set done.
  - Stepping (UP/DOWN): dwell counter counts 0..DWELL. FTW_CUR updates on the cycle the counter hits DWELL, so one step every DWELL+1 cycles.
  - UP: FTW_CUR <= min(FTW_CUR+STEP, FTW_STOP), computed without overflow (ACC_WIDTH+1 bits). On reaching STOP: one-shot → DONE and set done; triangle → DOWN.
  - DOWN: FTW_CUR <= max(FTW_CUR−STEP, FTW_START), no underflow. On reaching START → UP. Triangle never sets done.
  - STEP=0: FTW_CUR constant, state never advances.
  - DONE: FTW_CUR holds STOP until sweep_en written 0.
  - sweep_en written 0 in any state → IDLE next cycle.
  - Writes to START/STOP/STEP/DWELL during a sweep apply from the next step evaluation; no restart.
- Done flag: set on the DONE transition. W1C to STATUS b2 clears it. If set and clear occur in the same cycle, set wins.
- Sweep runs regardless of enable; enable only gates accumulation.
- Simultaneous write to channel k and read of channel j: both are serviced. A read of a register being written returns the pre-write value.

Test Plan:
- Reset, then read every register of ch0/ch1 → all 0, readdata valid exactly 1 cycle after read; o_phase=0, o_irq=0.
- Static tone: ch0 FTW_START=0x4000_0000, enable=1 → o_phase ch0 steps 0x0000,0x1000,0x2000,0x3000,0x0000 (wrap), one cycle apart; ch1 stays 0.
- One-shot sweep: START=100, STOP=130, STEP=12, DWELL=2, irq_en=1, sweep_en 0→1 → FTW_CUR 100,112,124,130 changing every 3 cycles; then state=3, done=1, o_irq=1. W1C STATUS b2 → o_irq=0.
- Triangle: START=10, STOP=20, STEP=5, DWELL=0 → FTW_CUR 10,15,20,15,10,15… each cycle, done never set. START=50, STOP=20 → immediate DONE.
- Phase control: PHASE_OFFSET=0x8000_0000 → o_phase MSB toggled versus no-offset. phase_clr while enabled → acc restarts from 0, then increments by FTW next cycle.
- Reset asserted mid-triangle sweep on ch1 → next cycle all state 0. Write to channel index N_CH is ignored and reads back 0.
